apb3_regbank_slave: RTL and testbench

//  APB3 completer with a small memory-mapped register bank; the peripheral slot behind the AXI4-to-APB3 bridge.

---
 rtl/apb3_regbank_slave_if.sv | 24 ++
 rtl/apb3_regbank_slave.sv | 116 +++++++++++
 tb/tb_apb3_regbank_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/apb3_regbank_slave_if.sv
// APB3 bus bundle between a requester and the register-bank completer.
interface apb3_regbank_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_regbank_slave.sv
// Zero-wait-state APB3 completer: ID, two scratch registers, counter control,
// a free-running cycle counter and a status/error-count register.
module apb3_regbank_slave #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_0400),
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'h4D49_4554)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  apb3_regbank_slave_if.slave    io_apb
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned ERRCNT_W = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [IDX_W-1:0] {
    REG_ID   = 3'd0,
    REG_SCR0 = 3'd1,
    REG_SCR1 = 3'd2,
    REG_CTRL = 3'd3,
    REG_CNT  = 3'd4,
    REG_STAT = 3'd5
  } reg_idx_e;

  logic [DATA_WIDTH-1:0] r_scratch0;
  logic [DATA_WIDTH-1:0] r_scratch1;
  logic                  r_ctrl_en;
  logic [CNT_W-1:0]      r_counter;
  logic [ERRCNT_W-1:0]   r_err_cnt;

  logic                  w_acc;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_win;
  logic                  w_aligned;
  logic                  w_legal;
  reg_idx_e              w_idx;
  logic                  w_ro;
  logic                  w_err;
  logic                  w_wr;
  logic                  w_clr;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  // Address decode; the window is six word registers starting at BASE_ADDR.
  always_comb begin
    w_acc     = io_apb.PSEL & io_apb.PENABLE;
    w_off     = io_apb.PADDR - BASE_ADDR;
    w_in_win  = (io_apb.PADDR >= BASE_ADDR) && (w_off < ADDR_WIDTH'(32'h18));
    w_aligned = (w_off[1:0] == 2'b00);
    w_legal   = w_in_win & w_aligned;
    w_idx     = reg_idx_e'(w_off[4:2]);
    w_ro      = (w_idx == REG_ID) || (w_idx == REG_CNT) || (w_idx == REG_STAT);
    w_err     = w_acc & (~w_legal | (io_apb.PWRITE & w_ro));
    w_wr      = w_acc & io_apb.PWRITE & ~w_err;
    w_clr     = w_wr & (w_idx == REG_CTRL) & io_apb.PWDATA[1];
  end

  // Read multiplexer; CNT_CLR is a pulse and never reads back.
  always_comb begin
    w_rd_mux = '0;
    case (w_idx)
      REG_ID:   w_rd_mux = ID_VALUE;
      REG_SCR0: w_rd_mux = r_scratch0;
      REG_SCR1: w_rd_mux = r_scratch1;
      REG_CTRL: w_rd_mux = DATA_WIDTH'(r_ctrl_en);
      REG_CNT:  w_rd_mux = DATA_WIDTH'(r_counter);
      REG_STAT: w_rd_mux = DATA_WIDTH'({r_err_cnt, 7'd0, r_ctrl_en});
      default:  w_rd_mux = '0;
    endcase
  end

  // Bus responses are combinational so every access completes in its access phase.
  always_comb begin
    io_apb.PREADY  = 1'b1;
    io_apb.PSLVERR = ~i_rst & w_err;
    io_apb.PRDATA  = '0;
    if (~i_rst && w_acc && ~io_apb.PWRITE && w_legal) begin
      io_apb.PRDATA = w_rd_mux;
    end
  end

  // Read-write registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_ctrl_en  <= 1'b0;
    end else if (w_wr) begin
      if (w_idx == REG_SCR0) r_scratch0 <= io_apb.PWDATA;
      if (w_idx == REG_SCR1) r_scratch1 <= io_apb.PWDATA;
      if (w_idx == REG_CTRL) r_ctrl_en  <= io_apb.PWDATA[0];
    end
  end

  // Cycle counter; a clear write wins over the increment on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_counter <= '0;
    end else if (w_clr) begin
      r_counter <= '0;
    end else if (r_ctrl_en) begin
      r_counter <= r_counter + CNT_W'(1);
    end
  end

  // Saturating count of erroring access phases.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb3_regbank_slave.sv
// Directed bench for apb3_regbank_slave: the driver queues expected responses,
// a monitor compares each access phase and checks idle/reset behaviour.
module tb_apb3_regbank_slave;

  localparam logic [31:0] ID = 32'h4D49_4554;

  logic clk = 1'b0;
  logic rst;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  apb3_regbank_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb3_regbank_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'h0000_0400),
    .ID_VALUE  (ID)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_apb(apb)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
    end
  endtask

  // Setup phase then access phase; expectation is queued as the access phase starts.
  task automatic xfer(input string nm, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    @(negedge clk);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = wdata;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.name  = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: samples 2 ns after each falling edge, well away from the rising edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (done) break;
      if (rst) begin
        check("rst_prdata",  apb.PRDATA, 32'h0);
        check("rst_pslverr", 32'(apb.PSLVERR), 32'h0);
        check("rst_pready",  32'(apb.PREADY), 32'h1);
        check("rst_scratch0", dut.r_scratch0, 32'h0);
        check("rst_scratch1", dut.r_scratch1, 32'h0);
        check("rst_ctrl_en",  32'(dut.r_ctrl_en), 32'h0);
        check("rst_counter",  dut.r_counter, 32'h0);
        check("rst_errcnt",   32'(dut.r_err_cnt), 32'h0);
      end else if (apb.PSEL && apb.PENABLE) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_access: got access to %h expected none", apb.PADDR);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_prdata"},  apb.PRDATA, e.rdata);
          check({e.name, "_pslverr"}, 32'(apb.PSLVERR), 32'(e.err));
          check({e.name, "_pready"},  32'(apb.PREADY), 32'h1);
        end
      end else begin
        check("idle_prdata", apb.PRDATA, 32'h0);
        if (!apb.PSEL) check("idle_pslverr", 32'(apb.PSLVERR), 32'h0);
      end
    end
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = 32'h0;
    apb.PWDATA  = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Basic ID / scratch accesses
    xfer("rd_id",      1'b0, 32'h400, 32'h0, ID,            1'b0);
    xfer("rd_scr0_0",  1'b0, 32'h404, 32'h0, 32'h0,         1'b0);
    xfer("wr_scr0",    1'b1, 32'h404, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer("rd_scr0",    1'b0, 32'h404, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer("wr_scr1",    1'b1, 32'h408, 32'h1234_5678, 32'h0, 1'b0);
    xfer("rd_scr0_b",  1'b0, 32'h404, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer("rd_scr1",    1'b0, 32'h408, 32'h0, 32'h1234_5678, 1'b0);

    // Setup phase with no access phase, then PENABLE without PSEL: neither writes
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 32'h404; apb.PWDATA = 32'h0;
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b1;
    @(negedge clk);
    apb.PENABLE = 1'b0;
    xfer("rd_scr0_c",  1'b0, 32'h404, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Counter: enabled at the write edge, counts from the next edge
    xfer("wr_ctrl_en", 1'b1, 32'h40C, 32'h1, 32'h0, 1'b0);
    idle(10);
    xfer("rd_cnt_a",   1'b0, 32'h410, 32'h0, 32'd11, 1'b0);
    xfer("rd_cnt_b",   1'b0, 32'h410, 32'h0, 32'd13, 1'b0);
    xfer("wr_ctrl_clr",1'b1, 32'h40C, 32'h3, 32'h0, 1'b0);
    xfer("rd_cnt_clr", 1'b0, 32'h410, 32'h0, 32'd1,  1'b0);
    xfer("rd_ctrl",    1'b0, 32'h40C, 32'h0, 32'h1,  1'b0);
    xfer("wr_ctrl_off",1'b1, 32'h40C, 32'h0, 32'h0,  1'b0);
    xfer("rd_cnt_frz1",1'b0, 32'h410, 32'h0, 32'd6,  1'b0);
    xfer("rd_cnt_frz2",1'b0, 32'h410, 32'h0, 32'd6,  1'b0);

    // Error cases
    xfer("wr_id_err",  1'b1, 32'h400, 32'h5, 32'h0, 1'b1);
    xfer("rd_id_keep", 1'b0, 32'h400, 32'h0, ID,    1'b0);
    xfer("rd_418_err", 1'b0, 32'h418, 32'h0, 32'h0, 1'b1);
    xfer("rd_3fc_err", 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b1);
    xfer("rd_406_err", 1'b0, 32'h406, 32'h0, 32'h0, 1'b1);
    xfer("rd_stat_4",  1'b0, 32'h414, 32'h0, 32'h0000_0400, 1'b0);
    xfer("wr_cnt_err", 1'b1, 32'h410, 32'h5, 32'h0, 1'b1);
    xfer("wr_stat_err",1'b1, 32'h414, 32'h5, 32'h0, 1'b1);
    xfer("wr_405_err", 1'b1, 32'h405, 32'h0, 32'h0, 1'b1);
    xfer("rd_cnt_keep",1'b0, 32'h410, 32'h0, 32'd6, 1'b0);
    xfer("rd_scr0_kp", 1'b0, 32'h404, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer("rd_stat_7",  1'b0, 32'h414, 32'h0, 32'h0000_0700, 1'b0);

    // Wrap: preload the counter near the top while it is enabled
    xfer("wr_ctrl_en2",1'b1, 32'h40C, 32'h1, 32'h0, 1'b0);
    @(negedge clk);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    force dut.r_counter = 32'hFFFF_FFFC;
    release dut.r_counter;
    xfer("rd_cnt_top", 1'b0, 32'h410, 32'h0, 32'hFFFF_FFFE, 1'b0);
    xfer("rd_cnt_wrap",1'b0, 32'h410, 32'h0, 32'h0000_0000, 1'b0);
    xfer("rd_stat_en", 1'b0, 32'h414, 32'h0, 32'h0000_0701, 1'b0);

    // Reset during an access phase of a SCRATCH0 read
    @(negedge clk);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h404;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    xfer("rd_scr0_rst",1'b0, 32'h404, 32'h0, 32'h0, 1'b0);
    xfer("rd_scr1_rst",1'b0, 32'h408, 32'h0, 32'h0, 1'b0);
    xfer("rd_ctrl_rst",1'b0, 32'h40C, 32'h0, 32'h0, 1'b0);
    xfer("rd_cnt_rst", 1'b0, 32'h410, 32'h0, 32'h0, 1'b0);
    xfer("rd_stat_rst",1'b0, 32'h414, 32'h0, 32'h0, 1'b0);
    idle(3);
    done = 1'b1;
  end

endmodule
